// File: rtl/pll_profile_switcher_if.sv
// Avalon-MM management port between the profile switcher and the PLL reconfig block.
interface pll_profile_switcher_if;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        mgmt_read;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address,
    output mgmt_writedata,
    output mgmt_write,
    output mgmt_read,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address,
    input  mgmt_writedata,
    input  mgmt_write,
    input  mgmt_read,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/pll_profile_switcher.sv
// Reprograms the reconfigurable PLL to a selected clock profile and holds the
// core in reset until the PLL has relocked and stayed stable.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for a profile request; core running (unless error)
// MODE        | writing polling mode (addr 0x00 = 1)
// WRITE       | writing the target profile's register table, entry wr_idx
// START       | writing the reconfig start trigger (addr 0x02 = 1)
// WAIT_BUSY   | waiting for the reconfig block to drop waitrequest
// WAIT_LOCK   | waiting for a stable lock, bounded by the timeout counter
module pll_profile_switcher #(
  parameter int NUM_PROFILES = 2,
  parameter int NUM_WRITES   = 8,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 1048576,
  localparam int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1,
  localparam int CW = $clog2(NUM_WRITES + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  input  logic [PW-1:0]                         req_profile,
  input  logic                                  req_force,
  output logic                                  req_ready,
  input  logic [NUM_PROFILES*NUM_WRITES*6-1:0]  prof_addr,
  input  logic [NUM_PROFILES*NUM_WRITES*32-1:0] prof_data,
  input  logic [NUM_PROFILES*CW-1:0]            prof_count,
  pll_profile_switcher_if.master                mgmt,
  input  logic                                  pll_locked,
  output logic                                  core_rst,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error,
  output logic [PW-1:0]                         cur_profile
);

  localparam int LW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MODE      = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_START     = 3'd3;
  localparam logic [2:0] S_WAIT_BUSY = 3'd4;
  localparam logic [2:0] S_WAIT_LOCK = 3'd5;

  logic [2:0]    state;
  logic [PW-1:0] target;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] cnt_raw;
  logic [CW-1:0] cnt_eff;
  logic [CW-1:0] wr_sel;
  logic [LW-1:0] lock_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          lock_meta;
  logic          lock_sync;
  logic          boot;
  logic          wr_accept;
  int            ent;

  assign cnt_raw = prof_count[int'(target)*CW +: CW];
  assign cnt_eff = (cnt_raw > CW'(NUM_WRITES)) ? CW'(NUM_WRITES) : cnt_raw;
  // Keep the table index in range when wr_idx has run past the last entry.
  assign wr_sel  = (wr_idx < CW'(NUM_WRITES)) ? wr_idx : '0;
  assign ent     = int'(target) * NUM_WRITES + int'(wr_sel);

  always_comb begin
    mgmt.mgmt_write     = 1'b0;
    mgmt.mgmt_address   = '0;
    mgmt.mgmt_writedata = '0;
    case (state)
      S_MODE: begin
        mgmt.mgmt_write     = 1'b1;
        mgmt.mgmt_address   = 6'h00;
        mgmt.mgmt_writedata = 32'h0000_0001;
      end
      S_WRITE: begin
        if (wr_idx < cnt_eff) begin
          mgmt.mgmt_write     = 1'b1;
          mgmt.mgmt_address   = prof_addr[ent*6 +: 6];
          mgmt.mgmt_writedata = prof_data[ent*32 +: 32];
        end
      end
      S_START: begin
        mgmt.mgmt_write     = 1'b1;
        mgmt.mgmt_address   = 6'h02;
        mgmt.mgmt_writedata = 32'h0000_0001;
      end
      default: ;
    endcase
  end

  assign mgmt.mgmt_read = 1'b0;
  assign wr_accept      = mgmt.mgmt_write & ~mgmt.mgmt_waitrequest;
  assign busy           = (state != S_IDLE);
  // Low during a no-op done pulse so a held req_valid is not taken twice.
  assign req_ready      = (state == S_IDLE) && !done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_WAIT_LOCK;
      target      <= '0;
      wr_idx      <= '0;
      lock_cnt    <= '0;
      tmo_cnt     <= '0;
      lock_meta   <= 1'b0;
      lock_sync   <= 1'b0;
      boot        <= 1'b1;
      cur_profile <= '0;
      core_rst    <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            error <= 1'b0;
            if (req_profile == cur_profile && !req_force) begin
              done <= 1'b1;
            end else begin
              target   <= req_profile;
              core_rst <= 1'b1;
              state    <= S_MODE;
            end
          end
        end
        S_MODE: begin
          if (wr_accept) begin
            wr_idx <= '0;
            // Skip straight to START so the writes stay back to back.
            state  <= (cnt_eff == '0) ? S_START : S_WRITE;
          end
        end
        S_WRITE: begin
          if (wr_idx >= cnt_eff) begin
            state <= S_START;
          end else if (wr_accept) begin
            wr_idx <= wr_idx + CW'(1);
            if (wr_idx + CW'(1) >= cnt_eff) state <= S_START;
          end
        end
        S_START: begin
          if (wr_accept) state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!mgmt.mgmt_waitrequest) begin
            cur_profile <= target;
            lock_cnt    <= '0;
            tmo_cnt     <= '0;
            state       <= S_WAIT_LOCK;
          end
        end
        S_WAIT_LOCK: begin
          if (tmo_cnt != TW'(LOCK_TIMEOUT)) tmo_cnt <= tmo_cnt + TW'(1);
          lock_cnt <= lock_sync ? lock_cnt + LW'(1) : '0;
          if (lock_sync && lock_cnt == LW'(LOCK_STABLE - 1)) begin
            core_rst <= 1'b0;
            done     <= !boot;
            boot     <= 1'b0;
            state    <= S_IDLE;
          end else if (tmo_cnt == TW'(LOCK_TIMEOUT - 1)) begin
            error <= 1'b1;
            boot  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_profile_switcher.sv
// Directed bench for pll_profile_switcher: a request vector table plus
// hand-written reset, timeout and mid-sequence reset scenarios.
module tb_pll_profile_switcher;
  localparam int NP = 2;
  localparam int NW = 8;
  localparam int LS = 16;
  localparam int LT = 100;
  localparam int PW = 1;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid = 1'b0;
  logic [PW-1:0]        req_profile = '0;
  logic                 req_force = 1'b0;
  logic                 req_ready;
  logic [NP*NW*6-1:0]   prof_addr;
  logic [NP*NW*32-1:0]  prof_data;
  logic [NP*CW-1:0]     prof_count;
  logic                 pll_locked = 1'b1;
  logic                 core_rst, busy, done, error;
  logic [PW-1:0]        cur_profile;

  pll_profile_switcher_if mgmt();

  pll_profile_switcher #(
    .NUM_PROFILES(NP), .NUM_WRITES(NW), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_profile(req_profile), .req_force(req_force),
    .req_ready(req_ready),
    .prof_addr(prof_addr), .prof_data(prof_data), .prof_count(prof_count),
    .mgmt(mgmt),
    .pll_locked(pll_locked),
    .core_rst(core_rst), .busy(busy), .done(done), .error(error),
    .cur_profile(cur_profile)
  );

  always #5 clk = ~clk;

  // Bus monitor / waitrequest driver, all on the falling edge.
  int          cyc = 0;
  logic [37:0] acc_q[$];
  logic [37:0] word_q[$];
  int          wcyc_q[$];
  int          done_cyc_q[$];
  logic        done_rst_q[$];
  logic        done_rdy_q[$];
  int          busy_fall_cyc = -1;
  logic        busy_prev = 1'b1;
  int          stall_at = -1;
  int          stall_len = 0;
  int          stall_cnt = 0;

  always @(negedge clk) begin
    logic wreq;
    cyc++;
    wreq = 1'b0;
    if (acc_q.size() != stall_at) stall_cnt = 0;
    if (mgmt.mgmt_write === 1'b1) begin
      wcyc_q.push_back(cyc);
      word_q.push_back({mgmt.mgmt_address, mgmt.mgmt_writedata});
      if (acc_q.size() == stall_at && stall_cnt < stall_len) begin
        wreq = 1'b1;
        stall_cnt++;
      end else begin
        acc_q.push_back({mgmt.mgmt_address, mgmt.mgmt_writedata});
      end
    end
    mgmt.mgmt_waitrequest = wreq;
    if (done === 1'b1) begin
      done_cyc_q.push_back(cyc);
      done_rst_q.push_back(core_rst);
      done_rdy_q.push_back(req_ready);
    end
    if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
    busy_prev = busy;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h wanted %0h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] tab_word(int p, int i);
    logic [5:0]  a;
    logic [31:0] d;
    a = 6'(8 + p*16 + i*3);
    d = 32'hA500_0000 | (32'(p) << 16) | 32'(i * 'h111);
    return {a, d};
  endfunction

  logic [37:0] exp_q[$];
  function automatic void build_exp(int p, int cnt);
    int n;
    n = (cnt > NW) ? NW : cnt;
    exp_q.delete();
    exp_q.push_back({6'h00, 32'h1});
    for (int i = 0; i < n; i++) exp_q.push_back(tab_word(p, i));
    exp_q.push_back({6'h02, 32'h1});
  endfunction

  task automatic chk_reset(input string t);
    chk({t, "_core_rst"}, core_rst, 1);
    chk({t, "_busy"}, busy, 1);
    chk({t, "_done"}, done, 0);
    chk({t, "_error"}, error, 0);
    chk({t, "_write"}, mgmt.mgmt_write, 0);
    chk({t, "_addr"}, mgmt.mgmt_address, 0);
    chk({t, "_wdata"}, mgmt.mgmt_writedata, 0);
    chk({t, "_read"}, mgmt.mgmt_read, 0);
    chk({t, "_req_ready"}, req_ready, 0);
    chk({t, "_cur_profile"}, cur_profile, 0);
  endtask

  task automatic start_req(input logic p, input logic f, output int acyc);
    int k;
    @(negedge clk);
    req_valid = 1'b1;
    req_profile = p;
    req_force = f;
    for (k = 0; k < 200 && req_ready !== 1'b1; k++) @(negedge clk);
    if (req_ready !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL req_accept: req_ready %b, wanted 1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acyc = cyc;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    if (k == budget) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_idle: busy %b after %0d cycles, wanted 0", tag, busy, budget);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic       prof;
    logic       frc;
    logic [3:0] cnt0;
    int         stall;
    logic       noop;
    int         nwr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   acyc, abase, wbase, dbase, n, cnt, last;
    vec_t v;
    logic [37:0] w11;

    vecs[0] = '{1'b1, 1'b0, 4'd2,  0, 1'b0, 5};
    vecs[1] = '{1'b1, 1'b0, 4'd2,  0, 1'b1, 0};
    vecs[2] = '{1'b1, 1'b1, 4'd2,  0, 1'b0, 5};
    vecs[3] = '{1'b0, 1'b0, 4'd2,  3, 1'b0, 4};
    vecs[4] = '{1'b0, 1'b0, 4'd2,  0, 1'b1, 0};
    vecs[5] = '{1'b0, 1'b1, 4'd15, 0, 1'b0, 10};
    vecs[6] = '{1'b0, 1'b1, 4'd0,  0, 1'b0, 2};

    for (int p = 0; p < NP; p++)
      for (int i = 0; i < NW; i++) begin
        w11 = tab_word(p, i);
        prof_addr[(p*NW+i)*6 +: 6]   = w11[37:32];
        prof_data[(p*NW+i)*32 +: 32] = w11[31:0];
      end
    prof_count = {4'd3, 4'd2};

    // Reset with lock already present: release 18 cycles later, no done.
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    repeat (17) @(negedge clk);
    chk("boot_core_rst_held", core_rst, 1);
    @(negedge clk);
    chk("boot_core_rst_rel", core_rst, 0);
    chk("boot_done", done, 0);
    chk("boot_busy", busy, 0);
    chk("boot_cur_profile", cur_profile, 0);
    @(negedge clk);
    chk("boot_req_ready", req_ready, 1);
    chk("boot_done_pulses", done_cyc_q.size(), 0);

    for (int k = 0; k < 7; k++) begin
      v = vecs[k];
      prof_count[CW-1:0] = v.cnt0;
      abase = acc_q.size();
      wbase = wcyc_q.size();
      dbase = done_cyc_q.size();
      stall_at = abase + 1;
      stall_len = v.stall;
      start_req(v.prof, v.frc, acyc);
      if (v.noop) begin
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_noop_writes", k), wcyc_q.size() - wbase, 0);
        chk($sformatf("v%0d_noop_done_n", k), done_cyc_q.size() - dbase, 1);
        if (done_cyc_q.size() > dbase) begin
          chk($sformatf("v%0d_noop_done_cyc", k), done_cyc_q[dbase], acyc + 1);
          chk($sformatf("v%0d_noop_ready", k), done_rdy_q[dbase], 0);
        end
        chk($sformatf("v%0d_noop_busy", k), busy, 0);
      end else begin
        pll_locked = 1'b0;
        repeat (50) @(negedge clk);
        pll_locked = 1'b1;
        wait_idle(400, $sformatf("v%0d", k));
        cnt = v.prof ? 3 : int'(v.cnt0);
        build_exp(int'(v.prof), cnt);
        n = acc_q.size() - abase;
        chk($sformatf("v%0d_nwr", k), n, v.nwr);
        for (int i = 0; i < exp_q.size() && i < n; i++)
          chk($sformatf("v%0d_w%0d", k, i), acc_q[abase+i], exp_q[i]);
        if (wcyc_q.size() > wbase) begin
          last = wcyc_q[wcyc_q.size()-1];
          chk($sformatf("v%0d_first_wr", k), wcyc_q[wbase], acyc + 1);
          chk($sformatf("v%0d_wr_cycles", k), wcyc_q.size() - wbase, v.nwr + v.stall);
          chk($sformatf("v%0d_wr_span", k), last - wcyc_q[wbase] + 1, v.nwr + v.stall);
        end
        if (v.stall > 0 && word_q.size() >= wbase + 5)
          for (int j = 1; j <= 4; j++)
            chk($sformatf("v%0d_hold%0d", k, j), word_q[wbase+j], exp_q[1]);
        chk($sformatf("v%0d_done_n", k), done_cyc_q.size() - dbase, 1);
        if (done_cyc_q.size() > dbase)
          chk($sformatf("v%0d_done_rst", k), done_rst_q[dbase], 0);
        chk($sformatf("v%0d_core_rst", k), core_rst, 0);
        chk($sformatf("v%0d_error", k), error, 0);
      end
      chk($sformatf("v%0d_cur_profile", k), cur_profile, v.prof);
    end
    stall_len = 0;

    // Lock never arrives: error after exactly LT cycles in WAIT_LOCK.
    prof_count[CW-1:0] = 4'd2;
    dbase = done_cyc_q.size();
    start_req(1'b1, 1'b1, acyc);
    pll_locked = 1'b0;
    wait_idle(400, "tmo");
    chk("tmo_error", error, 1);
    chk("tmo_core_rst", core_rst, 1);
    chk("tmo_req_ready", req_ready, 1);
    chk("tmo_done_n", done_cyc_q.size() - dbase, 0);
    chk("tmo_cur_profile", cur_profile, 1);
    chk("tmo_idle_cyc", busy_fall_cyc, wcyc_q[wcyc_q.size()-1] + 102);
    repeat (3) @(negedge clk);
    chk("tmo_error_sticky", error, 1);
    pll_locked = 1'b1;
    start_req(1'b0, 1'b0, acyc);
    chk("tmo_clr_error", error, 0);
    chk("tmo_clr_core_rst", core_rst, 1);
    wait_idle(400, "tmo_clr");
    chk("tmo_clr_rel", core_rst, 0);
    chk("tmo_clr_cur_profile", cur_profile, 0);

    // Reset while writing entry 1 of profile 1.
    abase = acc_q.size();
    dbase = done_cyc_q.size();
    start_req(1'b1, 1'b0, acyc);
    repeat (3) @(negedge clk);
    w11 = tab_word(1, 1);
    chk("mid_addr_i1", mgmt.mgmt_address, w11[37:32]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("mid");
    wbase = wcyc_q.size();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("mid_acc_n", acc_q.size() - abase, 3);
    chk("mid_no_more_writes", wcyc_q.size() - wbase, 0);
    chk("mid_done_n", done_cyc_q.size() - dbase, 0);
    chk("mid_core_rst", core_rst, 0);
    chk("mid_cur_profile", cur_profile, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
